// File: rtl/input_vector_stepper.sv
// input_vector_stepper
//   Operand source for the four-input function block. x1..x4 come from the
//   debounced board switches (manual), a pushbutton-stepped 4-bit counter
//   (step), or a prescaled free-running counter (auto); hold freezes all.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-high reset
//   sw[3:0]    raw switches; sw[3] -> x1 ... sw[0] -> x4
//   btn_step   raw pushbutton, active-high
//   mode[1:0]  00 manual, 01 step, 10 auto, 11 hold (static strap)
//   x1..x4     registered operand vector, x1 = MSB
//   vec_valid  one-cycle pulse in the cycle x1..x4 change
//   wrap       one-cycle pulse when the counter rolls 15 -> 0 (step/auto)
module input_vector_stepper #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_step,
    input  logic [1:0] mode,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       x4,
    output logic       vec_valid,
    output logic       wrap
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PW = $clog2(AUTO_PERIOD);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_STEP   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // bit 4 is the pushbutton, bits 3:0 the switches
    logic [4:0]          sync1;
    logic [4:0]          sync2;
    logic [4:0]          deb;
    logic [4:0][DW-1:0]  db_cnt;
    logic                btn_prev;
    logic                step_evt;

    mode_t               cur_mode;
    mode_t               mode_prev;
    logic [3:0]          cnt;
    logic [3:0]          cnt_n;
    logic [3:0]          x_vec;
    logic [3:0]          x_n;
    logic [PW-1:0]       pre;
    logic [PW-1:0]       pre_n;
    logic [PW-1:0]       pre_base;
    logic                wrap_n;

    assign cur_mode = mode_t'(mode);
    assign step_evt = deb[4] & ~btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            db_cnt    <= '0;
            btn_prev  <= 1'b0;
            mode_prev <= MODE_MANUAL;
            cnt       <= '0;
            pre       <= '0;
            x_vec     <= '0;
            vec_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            sync1 <= {btn_step, sw};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
            btn_prev  <= deb[4];
            mode_prev <= cur_mode;
            cnt       <= cnt_n;
            pre       <= pre_n;
            x_vec     <= x_n;
            vec_valid <= (x_n != x_vec);
            wrap      <= wrap_n;
        end
    end

    always_comb begin
        cnt_n    = cnt;
        pre_n    = pre;
        x_n      = x_vec;
        wrap_n   = 1'b0;
        // The entry edge counts as prescale step 1 from a cleared prescaler,
        // so the first auto increment lands AUTO_PERIOD edges after entry.
        pre_base = (cur_mode != mode_prev) ? '0 : pre;
        case (cur_mode)
            MODE_MANUAL: begin
                x_n = deb[3:0];
            end
            MODE_STEP: begin
                x_n = cnt;
                if (step_evt) begin
                    cnt_n  = cnt + 4'd1;
                    x_n    = cnt + 4'd1;
                    wrap_n = (cnt == 4'hF);
                end
            end
            MODE_AUTO: begin
                x_n = cnt;
                if (pre_base == PW'(AUTO_PERIOD - 1)) begin
                    pre_n  = '0;
                    cnt_n  = cnt + 4'd1;
                    x_n    = cnt + 4'd1;
                    wrap_n = (cnt == 4'hF);
                end else begin
                    pre_n = pre_base + PW'(1);
                end
            end
            default: begin
                // hold: x, cnt and prescaler keep their values
            end
        endcase
    end

    assign x1 = x_vec[3];
    assign x2 = x_vec[2];
    assign x3 = x_vec[1];
    assign x4 = x_vec[0];

endmodule

// File: tb/tb_input_vector_stepper.sv
// tb_input_vector_stepper
//   Directed bench for input_vector_stepper. Expected vector updates are
//   queued when stimulus is applied and popped on every vec_valid pulse;
//   timing-critical points are checked directly in the stimulus sequence.
module tb_input_vector_stepper;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic       btn_step;
    logic [1:0] mode;
    logic       x1, x2, x3, x4;
    logic       vec_valid;
    logic       wrap;
    logic [3:0] xv;

    typedef struct {
        logic [3:0] x;
        logic       w;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vv_count = 0;
    int   wrap_count = 0;

    input_vector_stepper #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .btn_step(btn_step),
        .mode(mode),
        .x1(x1),
        .x2(x2),
        .x3(x3),
        .x4(x4),
        .vec_valid(vec_valid),
        .wrap(wrap)
    );

    assign xv = {x1, x2, x3, x4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] x, input logic w);
        exp_t e;
        e.x = x;
        e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic press();
        btn_step = 1'b1;
        tick(8);
        btn_step = 1'b0;
        tick(8);
    endtask

    // scoreboard consumer: every vec_valid pulse must match the next queued update
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (wrap) begin
            wrap_count++;
            if (!vec_valid) chk("wrap_without_vec_valid", {31'd0, vec_valid}, 32'd1);
        end
        if (vec_valid) begin
            vv_count++;
            chk("sb_pending", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_x", {28'd0, xv}, {28'd0, e.x});
                chk("sb_wrap", {31'd0, wrap}, {31'd0, e.w});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vv0;
        int wr0;

        reset    = 1'b1;
        sw       = 4'b1011;
        btn_step = 1'b0;
        mode     = 2'b00;

        // reset and manual latency
        tick(3);
        chk("reset_x", {28'd0, xv}, 32'h0);
        chk("reset_vv", {31'd0, vec_valid}, 32'd0);
        chk("reset_wrap", {31'd0, wrap}, 32'd0);
        push(4'b1011, 1'b0);
        reset = 1'b0;
        tick(6);
        chk("manual_edge6_x", {28'd0, xv}, 32'h0);
        tick(1);
        chk("manual_edge7_x", {28'd0, xv}, 32'hB);
        chk("manual_edge7_vv", {31'd0, vec_valid}, 32'd1);
        tick(2);

        // 3-sample glitch is rejected
        vv0 = vv_count;
        sw = 4'b1010;
        tick(3);
        sw = 4'b1011;
        tick(12);
        chk("glitch3_x", {28'd0, xv}, 32'hB);
        chk("glitch3_vv", vv_count - vv0, 32'd0);

        // 4-sample pulse is accepted, then debounced back
        push(4'b1010, 1'b0);
        push(4'b1011, 1'b0);
        sw = 4'b1010;
        tick(4);
        sw = 4'b1011;
        tick(16);
        chk("pulse4_drained", exp_q.size(), 32'd0);
        chk("pulse4_x", {28'd0, xv}, 32'hB);

        // step mode: 17 presses from cnt=0
        vv0 = vv_count;
        wr0 = wrap_count;
        push(4'b0000, 1'b0);
        mode = 2'b01;
        tick(2);
        chk("step_entry_x", {28'd0, xv}, 32'h0);
        for (int i = 1; i <= 17; i++) begin
            push(4'(i), (i == 16));
            press();
        end
        chk("step17_x", {28'd0, xv}, 32'h1);
        chk("step17_vv", vv_count - vv0, 32'd18);
        chk("step17_wrap", wrap_count - wr0, 32'd1);

        // advance to cnt=14, then auto mode
        for (int i = 2; i <= 14; i++) begin
            push(4'(i), 1'b0);
            press();
        end
        chk("pre_auto_x", {28'd0, xv}, 32'hE);
        push(4'hF, 1'b0);
        push(4'h0, 1'b1);
        push(4'h1, 1'b0);
        mode = 2'b10;
        tick(7);
        chk("auto_edge7_x", {28'd0, xv}, 32'hE);
        tick(1);
        chk("auto_edge8_x", {28'd0, xv}, 32'hF);
        chk("auto_edge8_vv", {31'd0, vec_valid}, 32'd1);
        tick(7);
        chk("auto_edge15_x", {28'd0, xv}, 32'hF);
        tick(1);
        chk("auto_edge16_x", {28'd0, xv}, 32'h0);
        chk("auto_edge16_wrap", {31'd0, wrap}, 32'd1);
        tick(8);
        chk("auto_edge24_x", {28'd0, xv}, 32'h1);

        // step to 5, hold while pressing, resume
        mode = 2'b01;
        for (int i = 2; i <= 5; i++) begin
            push(4'(i), 1'b0);
            press();
        end
        chk("pre_hold_x", {28'd0, xv}, 32'h5);
        vv0 = vv_count;
        mode = 2'b11;
        for (int i = 0; i < 3; i++) press();
        mode = 2'b01;
        tick(3);
        chk("hold_x", {28'd0, xv}, 32'h5);
        chk("hold_vv", vv_count - vv0, 32'd0);
        push(4'h6, 1'b0);
        press();
        chk("after_hold_x", {28'd0, xv}, 32'h6);

        // auto to cnt=9, then asynchronous reset with prescaler at 5
        push(4'h7, 1'b0);
        push(4'h8, 1'b0);
        push(4'h9, 1'b0);
        mode = 2'b10;
        tick(24);
        chk("auto_cnt9_x", {28'd0, xv}, 32'h9);
        tick(5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_x", {28'd0, xv}, 32'h0);
        chk("async_reset_vv", {31'd0, vec_valid}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(7);
        chk("post_reset_edge7_x", {28'd0, xv}, 32'h0);
        push(4'h1, 1'b0);
        tick(1);
        chk("post_reset_edge8_x", {28'd0, xv}, 32'h1);
        chk("post_reset_edge8_vv", {31'd0, vec_valid}, 32'd1);
        tick(2);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_vector_stepper.md
Name: input_vector_stepper

Overview:
- Upstream stage for the four-input combinational function block.
- Produces the x1..x4 operand vector from one of three sources: debounced board switches, a pushbutton-stepped 4-bit counter, or a free-running auto-step counter.
- Lets the function be exercised row by row through its truth table (rows 0..15) on the lab board or in simulation.
- x1..x4 are registered, glitch-free levels that feed the function block directly.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive mismatching synchronized samples needed before a debounced value flips (min 1)
AUTO_PERIOD, 8, clock cycles between auto-mode increments (min 2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
sw  input  4  raw board switches; sw[3]->x1 … sw[0]->x4
btn_step  input  1  raw pushbutton, active-high
mode  input  2  00 manual, 01 step, 10 auto, 11 hold
x1  output  1  vector MSB (truth-table row bit 3)
x2  output  1  row bit 2
x3  output  1  row bit 1
x4  output  1  row bit 0 (LSB)
vec_valid  output  1  one-cycle pulse in the cycle x1..x4 take a new value
wrap  output  1  one-cycle pulse when the counter rolls over from 15 to 0

Behaviour:
- Reset, asynchronous and active-high, clears:
  - all synchronizer flops, debounced values, debounce counters and the button edge register;
  - the step counter (cnt) and the auto prescaler;
  - the outputs: x1..x4=0, vec_valid=0, wrap=0.
- Reset asserted mid-debounce or mid-prescale discards the partial count.
- mode is sampled directly (static strap) with no synchronizer.
- Synchronizer: each of sw[3:0] and btn_step passes through 2 flops.
- Debounce, per bit:
  - Counter increments on each edge where the synchronized bit differs from the debounced bit.
  - Counter clears on any edge where they match.
  - On the DEBOUNCE_CYCLES-th consecutive mismatch, the debounced bit flips and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized samples are ignored.
- Step event: asserted on the edge after the debounced button's 0->1 transition, so exactly one event per press. Release generates nothing.
- mode 00, manual:
  - x = debounced sw, registered one edge after the debounced value changes.
  - Latency with default parameters: sw change stable from before edge 1 -> x changes at edge 7.
  - cnt is unchanged and step events are ignored.
- mode 01, step: each step event does cnt <= cnt+1 (mod 16) and x <= new cnt on the same edge.
- mode 10, auto:
  - Prescaler counts 0..AUTO_PERIOD-1.
  - On the edge it wraps, cnt increments and x <= new cnt.
  - Prescaler clears on mode entry, so the first increment occurs AUTO_PERIOD edges after entry.
  - Step events are ignored.
- mode 11, hold: x, cnt and the prescaler are frozen; step events are discarded, not queued.
- Mode change:
  - cnt retains its value across all mode changes.
  - On entry to 01 or 10, x <= cnt on the first edge in the new mode; vec_valid pulses if x differs.
  - On entry to 00, x <= debounced sw on the first edge; vec_valid pulses if x differs.
- vec_valid is high exactly in cycles where x1..x4 differ from their previous-cycle value; it never pulses without a change.
- wrap pulses coincident with the x update from 15 to 0 in step or auto mode only. A manual 15->0 change gives vec_valid only.
- All arithmetic is 4-bit unsigned with natural overflow.
- No combinational path from any input to any output.

Test Plan:
- Reset with sw=4'b1011, mode=00, then release reset -> x=0000 during reset; x1..x4=1,0,1,1 at edge 7 with one vec_valid pulse; no wrap.
- mode=00, sw[0] glitch of 3 synchronized cycles (DEBOUNCE_CYCLES=4) -> x unchanged and vec_valid stays 0 throughout.
- mode=01, 17 clean button presses from cnt=0 -> x steps 1,2,…,15,0,1; 17 vec_valid pulses; one wrap pulse, at the 15->0 step.
- mode=10, AUTO_PERIOD=8, cnt=14 -> x=15 at 8 edges after entry, x=0 with wrap at 16 edges, x=1 at 24 edges.
- mode=01 at cnt=5, switch to 11 and press the button 3 times, then return to 01 -> x stays 0101, no vec_valid; the next press gives 0110.
- Assert reset mid-auto at cnt=9, prescaler=5 -> x=0000 immediately (asynchronous); after release, first increment occurs 8 edges later.
